// File: rtl/cnt_event_monitor.sv
// Observer for the up/down FSM counter: direction, compare match, overflow
// events, stall detection and an acknowledged interrupt. Timestamp via CNT_EVT_TS_EN.
module cnt_event_monitor #(
   parameter int CNTR_WDTH = 5,
   parameter int EVT_WDTH  = 4,
   parameter int STALL_CYC = 16,
   parameter int TS_WDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CNTR_WDTH-1:0] count,
   input  logic                 ovrflw,
   input  logic [CNTR_WDTH-1:0] cmp_val,
   input  logic                 cmp_en,
   input  logic                 irq_ack,
   output logic                 dir_up,
   output logic                 match_pls,
   output logic [EVT_WDTH-1:0]  ovf_cnt,
   output logic                 stall,
   output logic                 irq,
   output logic [1:0]           irq_src,
   output logic [TS_WDTH-1:0]   irq_ts
);

   localparam int SC_W = $clog2(STALL_CYC + 1);

   typedef enum logic {IDLE, PEND} state_t;

   function automatic logic [SC_W-1:0] stall_inc(input logic [SC_W-1:0] v);
      return (v == SC_W'(STALL_CYC)) ? v : v + SC_W'(1);
   endfunction

   function automatic logic [EVT_WDTH-1:0] evt_inc(input logic [EVT_WDTH-1:0] v);
      return (v == {EVT_WDTH{1'b1}}) ? v : v + EVT_WDTH'(1);
   endfunction

   logic [CNTR_WDTH-1:0] count_q;
   logic                 ovrflw_q;
   logic                 prime;
   logic [SC_W-1:0]      stall_ctr;
   state_t               state;

   logic [CNTR_WDTH-1:0] cnt_inc;
   logic [CNTR_WDTH-1:0] cnt_dec;
   logic                 changed;
   logic                 step_up;
   logic                 step_dn;
   logic                 match_evt;
   logic                 ovf_evt;
   logic [1:0]           evt;
   logic [SC_W-1:0]      stall_ctr_nxt;

   assign cnt_inc   = count_q + CNTR_WDTH'(1);
   assign cnt_dec   = count_q - CNTR_WDTH'(1);
   // Nothing is classified until prime is set, so the first sample is only a baseline.
   assign changed   = prime && (count != count_q);
   assign step_up   = changed && (count == cnt_inc);
   assign step_dn   = changed && (count == cnt_dec);
   assign match_evt = changed && cmp_en && (count == cmp_val);
   assign ovf_evt   = prime && ovrflw && !ovrflw_q;
   assign evt       = {match_evt, ovf_evt};

   always_comb begin
      stall_ctr_nxt = stall_ctr;
      if (prime) begin
         if (count == count_q)
            stall_ctr_nxt = stall_inc(stall_ctr);
         else
            stall_ctr_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         ovrflw_q  <= 1'b0;
         prime     <= 1'b0;
         stall_ctr <= '0;
         dir_up    <= 1'b1;
         match_pls <= 1'b0;
         ovf_cnt   <= '0;
         stall     <= 1'b0;
      end else begin
         count_q   <= count;
         ovrflw_q  <= ovrflw;
         prime     <= 1'b1;
         stall_ctr <= stall_ctr_nxt;
         stall     <= (stall_ctr_nxt == SC_W'(STALL_CYC));
         match_pls <= match_evt;
         if (step_up)
            dir_up <= 1'b1;
         else if (step_dn)
            dir_up <= 1'b0;
         if (ovf_evt)
            ovf_cnt <= evt_inc(ovf_cnt);
      end
   end

`ifdef CNT_EVT_TS_EN
   logic [TS_WDTH-1:0] ts_ctr;
   logic               ts_load;

   // Timestamp is taken whenever a fresh interrupt episode begins.
   assign ts_load = (|evt) && ((state == IDLE) || irq_ack);

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_ctr <= '0;
         irq_ts <= '0;
      end else begin
         ts_ctr <= ts_ctr + TS_WDTH'(1);
         if (ts_load)
            irq_ts <= ts_ctr;
      end
   end
`else
   assign irq_ts = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         irq     <= 1'b0;
         irq_src <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (|evt) begin
                  state   <= PEND;
                  irq     <= 1'b1;
                  irq_src <= evt;
               end
            end
            PEND: begin
               if (irq_ack) begin
                  // An event coinciding with the ack starts a new episode instead of being dropped.
                  if (|evt) begin
                     irq_src <= evt;
                  end else begin
                     state   <= IDLE;
                     irq     <= 1'b0;
                     irq_src <= 2'b00;
                  end
               end else begin
                  irq_src <= irq_src | evt;
               end
            end
            default: begin
               state   <= IDLE;
               irq     <= 1'b0;
               irq_src <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnt_event_monitor.sv
// Directed table-driven bench for cnt_event_monitor with hand sequences for
// overflow saturation, stall detection and mid-operation reset.
module tb_cnt_event_monitor;

   logic       clk;
   logic       rst;
   logic [4:0] count;
   logic       ovrflw;
   logic [4:0] cmp_val;
   logic       cmp_en;
   logic       irq_ack;
   logic       dir_up;
   logic       match_pls;
   logic [3:0] ovf_cnt;
   logic       stall;
   logic       irq;
   logic [1:0] irq_src;
   logic [15:0] irq_ts;

   int n_total = 0;
   int n_pass  = 0;

   cnt_event_monitor #(
      .CNTR_WDTH(5), .EVT_WDTH(4), .STALL_CYC(16), .TS_WDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .count(count), .ovrflw(ovrflw),
      .cmp_val(cmp_val), .cmp_en(cmp_en), .irq_ack(irq_ack),
      .dir_up(dir_up), .match_pls(match_pls), .ovf_cnt(ovf_cnt),
      .stall(stall), .irq(irq), .irq_src(irq_src), .irq_ts(irq_ts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [4:0] count;
      logic       ovf;
      logic       cen;
      logic [4:0] cval;
      logic       ack;
      logic       dir;
      logic       mat;
      logic [3:0] ovc;
      logic       stl;
      logic       irq;
      logic [1:0] src;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic r, input logic [4:0] c, input logic o,
                        input logic ce, input logic [4:0] cv, input logic a);
      rst = r; count = c; ovrflw = o; cmp_en = ce; cmp_val = cv; irq_ack = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic d, input logic m, input logic [3:0] oc,
                          input logic s, input logic i, input logic [1:0] sr);
      chk({tag, ".dir_up"}, 32'(dir_up), 32'(d));
      chk({tag, ".match_pls"}, 32'(match_pls), 32'(m));
      chk({tag, ".ovf_cnt"}, 32'(ovf_cnt), 32'(oc));
      chk({tag, ".stall"}, 32'(stall), 32'(s));
      chk({tag, ".irq"}, 32'(irq), 32'(i));
      chk({tag, ".irq_src"}, 32'(irq_src), 32'(sr));
   endtask

   initial begin
      drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

      //                rst cnt  ovf cen cval ack  dir mat ovc stl irq src
      tbl.push_back('{1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00}); // reset
      tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd1,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd2,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd3,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd4,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00}); // jump holds dir
      tbl.push_back('{1'b0, 5'd1,  1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd2,  1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd3,  1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd4,  1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 2'b10}); // match
      tbl.push_back('{1'b0, 5'd3,  1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b10});
      tbl.push_back('{1'b0, 5'd2,  1'b0, 1'b1, 5'd4,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b10});
      tbl.push_back('{1'b0, 5'd2,  1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00}); // ack
      tbl.push_back('{1'b0, 5'd30, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd31, 1'b0, 1'b0, 5'd4,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 5'd4,  1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 2'b01}); // up wrap + ovf
      tbl.push_back('{1'b0, 5'd1,  1'b0, 1'b0, 5'd4,  1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 2'b01});
      tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 2'b01});
      tbl.push_back('{1'b0, 5'd31, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 2'b01}); // down wrap
      tbl.push_back('{1'b0, 5'd30, 1'b0, 1'b1, 5'd30, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 2'b10}); // ack + match
      tbl.push_back('{1'b0, 5'd30, 1'b0, 1'b1, 5'd30, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 2'b00}); // ack alone
      tbl.push_back('{1'b0, 5'd29, 1'b1, 1'b1, 5'd29, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 2'b11}); // both events
      tbl.push_back('{1'b0, 5'd28, 1'b1, 1'b0, 5'd29, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 2'b11});
      tbl.push_back('{1'b0, 5'd28, 1'b0, 1'b0, 5'd29, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{1'b0, 5'd27, 1'b0, 1'b0, 5'd29, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 2'b00}); // ack in IDLE

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].count, tbl[i].ovf, tbl[i].cen, tbl[i].cval, tbl[i].ack);
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].dir, tbl[i].mat, tbl[i].ovc,
                 tbl[i].stl, tbl[i].irq, tbl[i].src);
      end

      // Overflow saturation: 20 more edges starting from ovf_cnt=2
      for (int e = 1; e <= 20; e++) begin
         drive(1'b0, 5'd27, 1'b1, 1'b0, 5'd29, 1'b0);
         tick();
         chk($sformatf("sat%0d.ovf_cnt", e), 32'(ovf_cnt), (e + 2 > 15) ? 32'd15 : 32'(e + 2));
         drive(1'b0, 5'd27, 1'b0, 1'b0, 5'd29, 1'b0);
         tick();
      end
      chk("sat.irq", 32'(irq), 32'd1);
      chk("sat.irq_src", 32'(irq_src), 32'd1);

      // Stall detection on count held at 7
      drive(1'b0, 5'd7, 1'b0, 1'b0, 5'd29, 1'b1);
      tick();
      chk("stall.entry.irq", 32'(irq), 32'd0);
      chk("stall.entry.stall", 32'(stall), 32'd0);
      for (int i = 1; i <= 20; i++) begin
         drive(1'b0, 5'd7, 1'b0, 1'b0, 5'd29, 1'b0);
         tick();
         chk($sformatf("stall%0d", i), 32'(stall), (i >= 16) ? 32'd1 : 32'd0);
      end
      drive(1'b0, 5'd6, 1'b0, 1'b0, 5'd29, 1'b0);
      tick();
      chk("stall.release.stall", 32'(stall), 32'd0);
      chk("stall.release.dir_up", 32'(dir_up), 32'd0);

      // Reset while an interrupt is pending
      drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      for (int e = 0; e < 3; e++) begin
         drive(1'b0, 5'(e + 1), 1'b1, 1'b0, 5'd0, 1'b0);
         tick();
         drive(1'b0, 5'(e + 1), 1'b0, 1'b0, 5'd0, 1'b0);
         tick();
      end
      chk("prerst.ovf_cnt", 32'(ovf_cnt), 32'd3);
      chk("prerst.irq", 32'(irq), 32'd1);
      drive(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      chk_all("midrst", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
`ifndef CNT_EVT_TS_EN
      chk("midrst.irq_ts", 32'(irq_ts), 32'd0);
`endif
      drive(1'b0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
      tick();
      chk_all("first_sample", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
      drive(1'b0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
      tick();
      chk("static_eq.match_pls", 32'(match_pls), 32'd0);
      drive(1'b0, 5'd8, 1'b0, 1'b1, 5'd9, 1'b0);
      tick();
      chk("post.dir_up", 32'(dir_up), 32'd0);
      drive(1'b0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0);
      tick();
      chk("post.match_pls", 32'(match_pls), 32'd1);
      chk("post.irq_src", 32'(irq_src), 32'd2);
      tick();
      chk("post.pulse_width", 32'(match_pls), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
